// File: rtl/scan_buf_pkg.sv
// Shared definitions for the scanner staging-buffer occupancy model.
// Holds the mode codes and the mode-priority helper.
package scan_buf_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_DRAIN = 2'b01,
        MODE_FILL  = 2'b10,
        MODE_FLUSH = 2'b11
    } mode_e;

    // Commands overlap, so a priority chain rather than a one-hot decode.
    function automatic mode_e next_mode(
        input logic  flush,
        input logic  scanning,
        input logic  transfer,
        input mode_e cur
    );
        if (flush) begin
            return MODE_FLUSH;
        end else if (scanning) begin
            return MODE_FILL;
        end else if (transfer) begin
            return MODE_DRAIN;
        end
        return cur;
    endfunction

endpackage

// File: rtl/scan_buffer_model_tick_gen.sv
// Update-tick divider: clock enable high one cycle in every TICK_DIV.
// Ports: clk, rst (async, active-low), tick (registered strobe).
module tick_gen #(
    parameter int TICK_DIV = 4194304
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick_q;
    logic          tick_d;

    // tick is registered from the next divider value, so it is high in
    // exactly the cycle the divider holds LAST, yet stays low in reset.
    always_comb begin
        div_d  = (div_q == LAST) ? '0 : div_q + DW'(1);
        tick_d = (div_d == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/scan_buffer_model.sv
// Occupancy model of the scanner staging buffer with watermark/event outputs.
// Ports: clk, rst (async low), scanning/transfer/flush in; count, mode, status, tick, drop, done out.
module scan_buffer_model
    import scan_buf_pkg::*;
#(
    parameter int CAPACITY   = 100,
    parameter int FILL_STEP  = 1,
    parameter int DRAIN_STEP = 2,
    parameter int TICK_DIV   = 4194304,
    parameter int LOW_MARK   = 10,
    parameter int HIGH_MARK  = 90,
    localparam int CW        = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scanning,
    input  logic          transfer,
    input  logic          flush,
    output logic [CW-1:0] data_count,
    output logic [1:0]    mode,
    output logic          empty,
    output logic          full,
    output logic          low_water,
    output logic          high_water,
    output logic          tick,
    output logic          drop,
    output logic          done
);

    if (TICK_DIV < 1) begin : g_bad_div
        $error("TICK_DIV must be at least 1");
    end
    if (LOW_MARK >= HIGH_MARK) begin : g_bad_marks
        $error("LOW_MARK must be below HIGH_MARK");
    end
    if (HIGH_MARK > CAPACITY) begin : g_bad_high
        $error("HIGH_MARK must not exceed CAPACITY");
    end

    localparam logic [CW:0]   CAP_X   = (CW + 1)'(CAPACITY);
    localparam logic [CW:0]   FILL_X  = (CW + 1)'(FILL_STEP);
    localparam logic [CW:0]   DRAIN_X = (CW + 1)'(DRAIN_STEP);
    localparam logic [CW-1:0] CAP_C   = CW'(CAPACITY);
    localparam logic [CW-1:0] LOW_C   = CW'(LOW_MARK);
    localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_MARK);

    mode_e         mode_q;
    mode_e         mode_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          drop_q;
    logic          drop_d;
    logic          done_q;
    logic          done_d;

    logic [CW:0]   fill_sum;
    logic [CW-1:0] fill_val;
    logic          drain_under;
    logic [CW-1:0] drain_val;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // One extra bit keeps the saturating add free of wrap-around.
    always_comb begin
        fill_sum    = {1'b0, count_q} + FILL_X;
        fill_val    = (fill_sum > CAP_X) ? CAP_C : fill_sum[CW-1:0];
        drain_under = ({1'b0, count_q} < DRAIN_X);
        drain_val   = drain_under ? '0 : count_q - DRAIN_X[CW-1:0];
    end

    always_comb begin
        mode_d  = next_mode(flush, scanning, transfer, mode_q);
        count_d = count_q;
        if (tick) begin
            unique case (mode_q)
                MODE_IDLE:  count_d = count_q;
                MODE_DRAIN: count_d = drain_val;
                MODE_FILL:  count_d = fill_val;
                MODE_FLUSH: count_d = '0;
            endcase
        end
        // Flush empties the buffer without waiting for a tick.
        if (flush) begin
            count_d = '0;
        end
        drop_d = tick && (mode_q == MODE_FILL) && (count_q == CAP_C);
        done_d = tick && (mode_q == MODE_DRAIN)
                 && (count_q != '0) && (drain_val == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_IDLE;
            count_q <= '0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
        end
    end

    assign data_count = count_q;
    assign mode       = mode_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CAP_C);
    assign low_water  = (count_q <= LOW_C);
    assign high_water = (count_q >= HIGH_C);
    assign drop       = drop_q;
    assign done       = done_q;

endmodule

// File: tb/tb_scan_buffer_model.sv
// Self-checking bench for scan_buffer_model with a behavioural occupancy model.
// Directed scenarios followed by a randomized command stream.
module tb_scan_buffer_model;

    localparam int CAP = 10;
    localparam int FS  = 1;
    localparam int DS  = 2;
    localparam int TD  = 4;
    localparam int LM  = 2;
    localparam int HM  = 8;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          scanning = 1'b0;
    logic          transfer = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] data_count;
    logic [1:0]    mode;
    logic          empty;
    logic          full;
    logic          low_water;
    logic          high_water;
    logic          tick;
    logic          drop;
    logic          done;

    int tests = 0;
    int fails = 0;

    // Reference state: mode as 0 idle, 1 drain, 2 fill, 3 flush.
    int    m_cnt;
    int    m_mode;
    int    m_edges;
    bit    m_tick;
    bit    m_drop;
    bit    m_done;
    string phase;

    scan_buffer_model #(
        .CAPACITY  (CAP),
        .FILL_STEP (FS),
        .DRAIN_STEP(DS),
        .TICK_DIV  (TD),
        .LOW_MARK  (LM),
        .HIGH_MARK (HM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scanning  (scanning),
        .transfer  (transfer),
        .flush     (flush),
        .data_count(data_count),
        .mode      (mode),
        .empty     (empty),
        .full      (full),
        .low_water (low_water),
        .high_water(high_water),
        .tick      (tick),
        .drop      (drop),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed %0h expected %0h",
                   phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(data_count), 32'(m_cnt));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("full", 32'(full), 32'(m_cnt == CAP));
        chk("low", 32'(low_water), 32'(m_cnt <= LM));
        chk("high", 32'(high_water), 32'(m_cnt >= HM));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("drop", 32'(drop), 32'(m_drop));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_mode  = 0;
        m_edges = 0;
        m_tick  = 0;
        m_drop  = 0;
        m_done  = 0;
    endtask

    // Called just after a rising edge; asserts reset mid-cycle.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b1;
    endtask

    // One clock: apply commands, advance the model, check after the edge.
    task automatic step(input bit s, input bit x, input bit f);
        int drained;
        int ncnt;
        scanning = s;
        transfer = x;
        flush    = f;
        @(posedge clk);
        drained = (m_cnt < DS) ? 0 : m_cnt - DS;
        m_drop  = m_tick && m_mode == 2 && m_cnt == CAP;
        m_done  = m_tick && m_mode == 1 && m_cnt != 0 && drained == 0;
        ncnt    = m_cnt;
        if (m_tick) begin
            case (m_mode)
                1: ncnt = drained;
                2: ncnt = (m_cnt + FS > CAP) ? CAP : m_cnt + FS;
                3: ncnt = 0;
                default: ncnt = m_cnt;
            endcase
        end
        if (f) ncnt = 0;
        m_cnt  = ncnt;
        m_mode = f ? 3 : s ? 2 : x ? 1 : m_mode;
        m_edges++;
        m_tick = (m_edges % TD) == TD - 1;
        #1;
        check_all();
    endtask

    task automatic fill_to(input int target);
        for (int i = 0; i < 200; i++) begin
            if (m_cnt == target) break;
            step(1, 0, 0);
        end
        chk("fill_to", 32'(data_count), 32'(target));
    endtask

    initial begin
        int drops;
        int dones;
        bit s;
        bit x;
        bit f;

        phase = "reset";
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) step(0, 0, 0);

        phase = "fill";
        drops = 0;
        for (int i = 0; i < 12 * TD; i++) begin
            step(1, 0, 0);
            if (drop) drops++;
        end
        chk("drop_total", 32'(drops), 32'd2);
        chk("fill_sat", 32'(data_count), 32'(CAP));

        phase = "drain";
        do_reset();
        fill_to(5);
        dones = 0;
        step(0, 1, 0);
        for (int i = 0; i < 6 * TD; i++) begin
            step(0, 0, 0);
            if (done) dones++;
        end
        chk("done_total", 32'(dones), 32'd1);
        chk("drain_mode", 32'(mode), 32'd1);

        phase = "flush";
        do_reset();
        fill_to(7);
        step(1, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 3 * TD; i++) step(0, 0, 0);
        for (int i = 0; i < 2 * TD; i++) step(1, 0, 0);

        phase = "both";
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        phase = "midreset";
        do_reset();
        fill_to(6);
        step(1, 0, 0);
        do_reset();
        for (int i = 0; i < 2 * TD; i++) step(0, 0, 0);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 2) == 0);
            x = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 15) == 0);
            step(s, x, f);
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_buffer_model.md
# scan_buffer_model

Parametrised occupancy model for the scanner's staging buffer. It tracks how many records are held while the scanner fills the buffer and the transfer path drains it, at a slow, parameterised tick rate. It reports watermark, full and empty status, lost-data and drain-complete events to the scanner control FSM and the display logic. It replaces the fixed-capacity, derived-clock counter with a single-clock design: the divider output is a clock enable, not a clock.

## Interface
Parameters:
- CAPACITY, 100: maximum occupancy; count saturates here.
- FILL_STEP, 1: increment per tick in FILL.
- DRAIN_STEP, 2: decrement per tick in DRAIN.
- TICK_DIV, 4194304: clk cycles per update tick; must be ≥ 1.
- LOW_MARK, 10: low_water threshold; must be < HIGH_MARK.
- HIGH_MARK, 90: high_water threshold; must be ≤ CAPACITY.
- CW (localparam): $clog2(CAPACITY+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- scanning  in  1  level; request FILL.
- transfer  in  1  level; request DRAIN.
- flush  in  1  level; request FLUSH.
- data_count  out  CW  current occupancy.
- mode  out  2  current mode code.
- empty  out  1  data_count == 0.
- full  out  1  data_count == CAPACITY.
- low_water  out  1  data_count ≤ LOW_MARK.
- high_water  out  1  data_count ≥ HIGH_MARK.
- tick  out  1  one-cycle update strobe.
- drop  out  1  one-cycle pulse; a FILL tick occurred while full.
- done  out  1  one-cycle pulse; a DRAIN tick brought a nonzero count to 0.

## Operation
- Mode codes: IDLE=00, DRAIN=01, FILL=10, FLUSH=11.
- The mode register is updated every clk by priority:
  - flush → FLUSH.
  - else scanning → FILL.
  - else transfer → DRAIN.
  - else hold the current mode (modes are sticky).
- scanning and transfer asserted together: the result is FILL.
- Tick generator:
  - Divider counter runs 0..TICK_DIV-1 and wraps.
  - tick is high in the cycle the counter equals TICK_DIV-1.
  - When TICK_DIV=1, tick is always high.
  - flush and mode changes do not reset the divider.
- Count update, evaluated on the edge where tick=1 and using the registered mode:
  - IDLE: hold.
  - FILL: count ← min(count+FILL_STEP, CAPACITY), computed at CW+1 bits.
  - DRAIN: count ← 0 if count < DRAIN_STEP, else count−DRAIN_STEP.
  - FLUSH: count ← 0.
- Flush is immediate: a clk edge with flush=1 sampled sets count to 0, regardless of tick.
- drop pulses when the mode is FILL, tick=1 and count==CAPACITY.
- done pulses when the mode is DRAIN, tick=1, count≠0 and the next count is 0. Draining an already-empty buffer gives no done.
- Status outputs are combinational from the data_count register.

## Timing
- Reset (asynchronous assert, synchronous release): data_count=0, mode=IDLE, divider=0, tick=0, drop=0, done=0. empty=1, low_water=1, full=0, high_water=0.
- A command sampled at edge N sets mode after edge N. The count first changes at the first tick edge after N, so latency is between 1 and TICK_DIV cycles.
- flush sampled at edge N: data_count=0 and mode=FLUSH after edge N.
- drop and done are registered. They are high for exactly the one cycle following the tick edge that caused them.
- Reset asserted mid-operation: all state clears immediately. The tick phase restarts from 0.

## Structure
- Shared package scan_buf_pkg holds the mode codes (IDLE, DRAIN, FILL, FLUSH) as a 2-bit typedef.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick) holds the divider counter.
- The top level holds the mode register, count datapath, status logic and event pulses.

## Test plan
All scenarios use CAPACITY=10, FILL_STEP=1, DRAIN_STEP=2, TICK_DIV=4, LOW_MARK=2, HIGH_MARK=8.
- Reset release, no commands → data_count=0, mode=00, empty=1, tick high every 4th cycle.
- scanning held 12 ticks → count 1..10 then holds; high_water at 8; full at 10; drop pulses on ticks 11 and 12.
- Count=5, transfer pulsed for 1 cycle → mode sticky DRAIN; count 3, 1, 0; done pulses once on the 1→0 tick; further ticks give count 0 and no done.
- Count=7, flush in a non-tick cycle → count=0 on the next edge; mode=11; later ticks keep 0 until scanning is asserted.
- scanning and transfer both high, then flush added → FILL while both are held; flush overrides to FLUSH the next cycle.
- rst low mid-FILL at count=6 → immediate count=0, mode=00, outputs at reset values; after release the first tick occurs 4 cycles later.
